// File: rtl/apb_i2c_cmd_master_if.sv
// apb_i2c_cmd_master_if: command, response and APB signals of apb_i2c_cmd_master
interface apb_i2c_cmd_master_if;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, busy, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, busy, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_i2c_cmd_master.sv
// apb_i2c_cmd_master: turns valid/ready register commands into single APB SETUP+ACCESS transfers
// Define APB_TIMEOUT_EN to abort ACCESS after TMO_CYCLES stalled cycles.
module apb_i2c_cmd_master #(
  parameter int TMO_CYCLES = 255,
  parameter int TMO_W      = 8
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_i2c_cmd_master_if.master m
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  if (TMO_CYCLES >= (1 << TMO_W)) begin : g_tmo_check
    $error("TMO_CYCLES does not fit in TMO_W bits");
  end
  assign m.cmd_ready = state == IDLE;
  assign m.busy      = state != IDLE;
`ifdef APB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
`endif
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state       <= IDLE;
      m.psel      <= 1'b0;
      m.penable   <= 1'b0;
      m.pwrite    <= 1'b0;
      m.paddr     <= '0;
      m.pwdata    <= '0;
      m.rsp_valid <= 1'b0;
      m.rsp_rdata <= '0;
      m.rsp_err   <= 1'b0;
      m.rsp_tmo   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else
      case (state)
        IDLE:
          if (m.cmd_valid) begin
            m.pwrite <= m.cmd_write;
            m.paddr  <= m.cmd_addr;
            m.pwdata <= m.cmd_wdata;
            m.psel   <= 1'b1;
            state    <= SETUP;
          end
        SETUP: begin
          m.penable <= 1'b1;
          state     <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        ACCESS:
          if (m.pready) begin
            m.rsp_rdata <= m.pwrite ? '0 : m.prdata;
            m.rsp_err   <= m.pslverr;
            m.rsp_tmo   <= 1'b0;
            m.psel      <= 1'b0;
            m.penable   <= 1'b0;
            m.rsp_valid <= 1'b1;
            state       <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TMO_CYCLES)) begin
            m.rsp_rdata <= '0;
            m.rsp_err   <= 1'b1;
            m.rsp_tmo   <= 1'b1;
            m.psel      <= 1'b0;
            m.penable   <= 1'b0;
            m.rsp_valid <= 1'b1;
            state       <= RESP;
          end else
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
        RESP:
          if (m.rsp_ready) begin
            m.rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_apb_i2c_cmd_master.sv
// tb_apb_i2c_cmd_master: random and directed commands checked each cycle against a phase-timing model
module tb_apb_i2c_cmd_master;
  localparam int TMO = 16;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  int n_chk = 0, n_pass = 0;
  logic chk_en = 1'b0, hold_valid = 1'b0;
  logic e_psel, e_pen, e_rv, e_ready, e_busy;
  logic m_pwrite, m_err, m_tmo;
  logic [31:0] m_paddr, m_pwdata, m_rdata;
  int cur_c = 0, pen_cnt = 0, rv_cnt = 0, rv_first = -1;
  logic [31:0] cap_rdata = '0;
  logic cap_err = 1'b0, cap_tmo = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_i2c_cmd_master_if bus();
  apb_i2c_cmd_master #(.TMO_CYCLES(TMO), .TMO_W(8)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .m(bus.master));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge PCLK)
    if (chk_en) begin
      chk("psel", bus.psel, e_psel);
      chk("penable", bus.penable, e_pen);
      chk("cmd_ready", bus.cmd_ready, e_ready);
      chk("busy", bus.busy, e_busy);
      chk("rsp_valid", bus.rsp_valid, e_rv);
      chk("pwrite", bus.pwrite, m_pwrite);
      chk("paddr", bus.paddr, m_paddr);
      chk("pwdata", bus.pwdata, m_pwdata);
      chk("rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("rsp_err", bus.rsp_err, m_err);
      chk("rsp_tmo", bus.rsp_tmo, m_tmo);
      if (bus.penable) pen_cnt++;
      if (bus.rsp_valid) rv_cnt++;
      if (bus.rsp_valid && rv_first < 0) begin
        rv_first  = cur_c;
        cap_rdata = bus.rsp_rdata;
        cap_err   = bus.rsp_err;
        cap_tmo   = bus.rsp_tmo;
      end
    end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_idle_exp();
    e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0; e_ready = 1'b1; e_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle_exp();
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = $urandom;
      bus.pready    = 1'($urandom_range(0, 1));
      bus.pslverr   = 1'($urandom_range(0, 1));
      bus.prdata    = $urandom;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // Cycle c counts from the accept cycle: SETUP at 1, ACCESS 2..2+w, RESP 3+w..3+w+d.
  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic er, input int w, input int d);
    int ew;
    logic to;
    ew = w;
    to = 1'b0;
`ifdef APB_TIMEOUT_EN
    if (w > TMO) begin
      to = 1'b1;
      ew = TMO;
    end
`endif
    pen_cnt = 0; rv_cnt = 0; rv_first = -1;
    for (int c = 0; c <= 3 + ew + d; c++) begin
      cur_c   = c;
      e_psel  = c >= 1 && c <= 2 + ew;
      e_pen   = c >= 2 && c <= 2 + ew;
      e_ready = c == 0;
      e_busy  = c != 0;
      e_rv    = c >= 3 + ew;
      if (c == 1) begin
        m_pwrite = wr; m_paddr = a; m_pwdata = wd;
      end
      if (c == 3 + ew) begin
        m_rdata = (to || wr) ? 32'h0 : rd;
        m_err   = to | er;
        m_tmo   = to;
      end
      bus.cmd_valid = (c == 0) || hold_valid || 1'($urandom_range(0, 1));
      bus.cmd_write = c == 0 ? wr : 1'($urandom_range(0, 1));
      bus.cmd_addr  = c == 0 ? a : $urandom;
      bus.cmd_wdata = c == 0 ? wd : $urandom;
      bus.pready    = (c == 2 + w) ? 1'b1 : (c >= 2 && c < 2 + w) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.prdata    = (c == 2 + w) ? rd : $urandom;
      bus.pslverr   = (c == 2 + w) ? er : 1'($urandom_range(0, 1));
      bus.rsp_ready = (c >= 3 + ew) ? (c == 3 + ew + d) : 1'($urandom_range(0, 1));
      step();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    m_pwrite = 1'b0; m_err = 1'b0; m_tmo = 1'b0; m_paddr = '0; m_pwdata = '0; m_rdata = '0;
    set_idle_exp();
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_psel", bus.psel, 32'h0);
    chk("reset_penable", bus.penable, 32'h0);
    chk("reset_rsp_valid", bus.rsp_valid, 32'h0);
    chk("reset_paddr", bus.paddr, 32'h0);
    chk("reset_cmd_ready", bus.cmd_ready, 32'h1);
    PRESETn = 1'b1;
    chk_en = 1'b1;
    idle(2);

    run_cmd(1'b1, 32'h4, 32'hA5, 32'h0, 1'b0, 0, 0);
    chk("t1_rsp_cycle", rv_first, 32'd3);
    chk("t1_penable_cycles", pen_cnt, 32'd1);
    chk("t1_rdata", cap_rdata, 32'h0);

    run_cmd(1'b0, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 3, 0);
    chk("t2_rsp_cycle", rv_first, 32'd6);
    chk("t2_penable_cycles", pen_cnt, 32'd4);
    chk("t2_rdata", cap_rdata, 32'h1234_5678);

    hold_valid = 1'b1;
    run_cmd(1'b0, 32'hC, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 5);
    hold_valid = 1'b0;
    chk("t3_rsp_valid_cycles", rv_cnt, 32'd6);

    run_cmd(1'b1, 32'h10, 32'h5A, 32'h0, 1'b1, 0, 0);
    chk("t4_err", cap_err, 32'h1);
    chk("t4_tmo", cap_tmo, 32'h0);
    run_cmd(1'b0, 32'h10, 32'h0, 32'h77, 1'b0, 1, 0);
    chk("t4_next_err", cap_err, 32'h0);
    chk("t4_next_rdata", cap_rdata, 32'h77);

    run_cmd(1'b0, 32'h18, 32'h0, 32'hA1, 1'b0, TMO, 0);
    chk("tmo_edge_tmo", cap_tmo, 32'h0);
    chk("tmo_edge_penable_cycles", pen_cnt, TMO + 1);

    run_cmd(1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, 1000, 0);
`ifdef APB_TIMEOUT_EN
    chk("t5_penable_cycles", pen_cnt, 32'd17);
    chk("t5_tmo", cap_tmo, 32'h1);
    chk("t5_err", cap_err, 32'h1);
    chk("t5_rdata", cap_rdata, 32'h0);
`else
    chk("t5_penable_cycles", pen_cnt, 32'd1001);
    chk("t5_tmo", cap_tmo, 32'h0);
    chk("t5_rdata", cap_rdata, 32'hDEAD_BEEF);
`endif

    repeat (40) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 2) : $urandom_range(0, 4);
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3) == 0, w, $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h20; bus.pready = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    chk("t6_pre_reset_penable", bus.penable, 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    chk("t6_reset_psel", bus.psel, 32'h0);
    chk("t6_reset_penable", bus.penable, 32'h0);
    chk("t6_reset_rsp_valid", bus.rsp_valid, 32'h0);
    step();
    step();
    PRESETn = 1'b1;
    m_pwrite = 1'b0; m_err = 1'b0; m_tmo = 1'b0; m_paddr = '0; m_pwdata = '0; m_rdata = '0;
    chk("t6_cmd_ready", bus.cmd_ready, 32'h1);
    chk_en = 1'b1;
    run_cmd(1'b0, 32'h0, 32'h0, 32'hCAFE_0001, 1'b0, 0, 0);
    chk("t6_rsp_cycle", rv_first, 32'd3);
    chk("t6_rdata", cap_rdata, 32'hCAFE_0001);
    idle(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
